kpn_fire_scheduler: RTL

Central firing controller for the fixed-point KPN datapath. It decides which process node (queue source, adder, split, LCD sink) may fire next, based on per-node input-token availability and output-space flags derived from the FIFOs. It issues one-cycle fire pulses in round-robin order, one node at a time, and waits for completion. It also flags hung nodes (timeout) and network deadlock.

---
 rtl/kpn_fire_scheduler_pkg.sv | 27 ++
 rtl/kpn_fire_scheduler_rr_arbiter.sv | 32 +++
 rtl/kpn_fire_scheduler.sv | 176 +++++++++++++++++
 3 files changed

// File: rtl/kpn_fire_scheduler_pkg.sv
// Shared definitions for the KPN firing controller and its helpers.
// Latency: none (types, constants and elaboration-time functions only).
// Backpressure: not applicable.
package kpn_fire_scheduler_pkg;

  // Scheduler phases: idle, arbitrating, firing pulse, waiting for completion.
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_ARB  = 2'd1,
    ST_FIRE = 2'd2,
    ST_WAIT = 2'd3
  } sched_state_t;

  // Width of the completed-firing counter.
  localparam int FIRE_COUNT_W = 16;

  // Bits needed to hold an index in [0, value-1]; never less than one bit.
  function automatic int clog2(input int value);
    int w;
    w = 1;
    while ((1 << w) < value) begin
      w = w + 1;
    end
    return w;
  endfunction

endpackage

// File: rtl/kpn_fire_scheduler_rr_arbiter.sv
// Combinational round-robin picker: first set request strictly after ptr, with wrap.
// Latency: zero cycles (pure combinational).
// Backpressure: none; grant_valid low when no request is set.
module rr_arbiter
  import kpn_fire_scheduler_pkg::*;
#(
  parameter int NUM_REQ = 4,
  localparam int IDX_W = clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] eligible,
  input  logic [IDX_W-1:0]   ptr,
  output logic [IDX_W-1:0]   grant_idx,
  output logic               grant_valid
);

  logic [IDX_W-1:0] idx;

  // Walk offsets from farthest to nearest so the nearest eligible index after ptr wins.
  always_comb begin
    grant_idx   = '0;
    grant_valid = 1'b0;
    idx         = '0;
    for (int k = NUM_REQ; k >= 1; k--) begin
      idx = IDX_W'((int'(ptr) + k) % NUM_REQ);
      if (eligible[idx]) begin
        grant_idx   = idx;
        grant_valid = 1'b1;
      end
    end
  end

endmodule

// File: rtl/kpn_fire_scheduler.sv
// Round-robin firing controller for KPN process nodes; one node in flight, with hang and deadlock flags.
// Latency: eligibility seen in an ARB cycle gives proc_fire next cycle; firing period 2 (done in FIRE) or 3+ cycles.
// Backpressure: a node fires only when all its inputs hold tokens and all its outputs have space.
module kpn_fire_scheduler
  import kpn_fire_scheduler_pkg::*;
#(
  parameter int NUM_PROC        = 4,
  parameter int TIMEOUT_CYCLES  = 64,
  parameter int DEADLOCK_CYCLES = 256
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       enable,
  input  logic [NUM_PROC-1:0]        proc_in_avail,
  input  logic [NUM_PROC-1:0]        proc_out_space,
  input  logic [NUM_PROC-1:0]        proc_done,
  output logic [NUM_PROC-1:0]        proc_fire,
  output logic [clog2(NUM_PROC)-1:0] grant_id,
  output logic                       busy,
  output logic                       timeout_err,
  output logic                       deadlock,
  output logic [FIRE_COUNT_W-1:0]    fire_count
);

  localparam int IDX_W = clog2(NUM_PROC);
  localparam int TMR_W = clog2(TIMEOUT_CYCLES + 1);
  localparam int IDL_W = clog2(DEADLOCK_CYCLES + 1);

  localparam logic [IDX_W-1:0] PTR_RESET = IDX_W'(NUM_PROC - 1);
  localparam logic [TMR_W-1:0] TMR_LIMIT = TMR_W'(TIMEOUT_CYCLES);
  localparam logic [IDL_W-1:0] IDL_LIMIT = IDL_W'(DEADLOCK_CYCLES);
  localparam logic [IDL_W-1:0] IDL_LAST  = IDL_W'(DEADLOCK_CYCLES - 1);

  sched_state_t state, state_nxt;

  logic [NUM_PROC-1:0] eligible;
  logic [NUM_PROC-1:0] fire_vec;
  logic [IDX_W-1:0]    ptr;
  logic [IDX_W-1:0]    arb_idx;
  logic                arb_valid;
  logic [TMR_W-1:0]    timer;
  logic [IDL_W-1:0]    idle_cnt;
  logic                done_granted;
  logic                do_grant;
  logic                do_complete;
  logic                do_timeout;
  logic                do_idle;

  assign eligible     = proc_in_avail & proc_out_space;
  // Only the granted node's done bit means anything; all others are ignored.
  assign done_granted = proc_done[grant_id];

  rr_arbiter #(
    .NUM_REQ(NUM_PROC)
  ) u_rr_arbiter (
    .eligible   (eligible),
    .ptr        (ptr),
    .grant_idx  (arb_idx),
    .grant_valid(arb_valid)
  );

  // State register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= ST_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state decode plus single-cycle event strobes consumed by the datapath registers.
  always_comb begin
    state_nxt   = state;
    do_grant    = 1'b0;
    do_complete = 1'b0;
    do_timeout  = 1'b0;
    do_idle     = 1'b0;
    unique case (state)
      ST_IDLE: begin
        if (enable) state_nxt = ST_ARB;
      end
      ST_ARB: begin
        if (!enable) begin
          state_nxt = ST_IDLE;
        end else if (arb_valid) begin
          state_nxt = ST_FIRE;
          do_grant  = 1'b1;
        end else begin
          do_idle = 1'b1;
        end
      end
      ST_FIRE: begin
        // A node may finish within its fire cycle; treat that as a normal completion.
        if (done_granted) begin
          state_nxt   = ST_ARB;
          do_complete = 1'b1;
        end else begin
          state_nxt = ST_WAIT;
        end
      end
      ST_WAIT: begin
        // Done wins over timeout when both land on the same cycle.
        if (done_granted) begin
          state_nxt   = ST_ARB;
          do_complete = 1'b1;
        end else if (timer == TMR_LIMIT) begin
          state_nxt  = ST_ARB;
          do_timeout = 1'b1;
        end
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  // One-hot decode of the arbiter's pick.
  always_comb begin
    fire_vec          = '0;
    fire_vec[arb_idx] = 1'b1;
  end

  // Registered fire pulse, busy flag and last-granted index.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      proc_fire <= '0;
      busy      <= 1'b0;
      grant_id  <= '0;
    end else begin
      proc_fire <= do_grant ? fire_vec : '0;
      busy      <= (state_nxt == ST_FIRE) || (state_nxt == ST_WAIT);
      if (do_grant) grant_id <= arb_idx;
    end
  end

  // Round-robin pointer advances to the node that just finished or hung; firing timer starts at 1 in FIRE.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ptr   <= PTR_RESET;
      timer <= '0;
    end else begin
      if (do_complete || do_timeout) ptr <= grant_id;
      if (do_grant) begin
        timer <= TMR_W'(1);
      end else if ((state == ST_FIRE) || (state == ST_WAIT)) begin
        timer <= timer + 1'b1;
      end
    end
  end

  // Saturating completion counter and sticky hung-node flag.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      fire_count  <= '0;
      timeout_err <= 1'b0;
    end else begin
      if (do_complete && (fire_count != {FIRE_COUNT_W{1'b1}})) begin
        fire_count <= fire_count + 1'b1;
      end
      if (do_timeout) timeout_err <= 1'b1;
    end
  end

  // Consecutive no-eligible ARB cycles; saturates at the limit and raises deadlock until a grant or IDLE.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      idle_cnt <= '0;
      deadlock <= 1'b0;
    end else if ((state == ST_IDLE) || do_grant) begin
      idle_cnt <= '0;
      deadlock <= 1'b0;
    end else if (do_idle) begin
      if (idle_cnt != IDL_LIMIT) idle_cnt <= idle_cnt + 1'b1;
      if (idle_cnt >= IDL_LAST) deadlock <= 1'b1;
    end
  end

endmodule
